// File: rtl/pixel_replication.sv
// Nearest-neighbour 1x/2x/4x upscaler: raster-scans the output frame, reads the source pixel, writes it 2 cycles later.
// Optional line buffer (PIXEL_REPLICATION_ROW_BUFFER_EN) serves replicated rows without re-reading source memory.
module pixel_replication #(
  parameter int SRC_W = 160,
  parameter int SRC_H = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [2:0]  zoom_level,
  input  logic [7:0]  pixel_in,
  output logic [14:0] read_addr,
  output logic        read_en,
  output logic [7:0]  pixel_out,
  output logic [18:0] write_addr,
  output logic        write_en,
  output logic        done
);
  localparam int XSW = $clog2(SRC_W);
  localparam int YSW = $clog2(SRC_H);
  localparam logic [9:0] XM0 = 10'(SRC_W - 1);
  localparam logic [9:0] XM1 = 10'(2 * SRC_W - 1);
  localparam logic [9:0] XM2 = 10'(4 * SRC_W - 1);
  localparam logic [8:0] YM0 = 9'(SRC_H - 1);
  localparam logic [8:0] YM1 = 9'(2 * SRC_H - 1);
  localparam logic [8:0] YM2 = 9'(4 * SRC_H - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t      r_state;
  logic [1:0]  r_shift;
  logic [9:0]  r_x, r_xmax;
  logic [8:0]  r_y, r_ymax;
  logic [18:0] r_oaddr, r_wa1;
  logic        r_flush, r_v1;

  logic            w_run, w_last;
  logic [XSW-1:0]  w_xsrc;
  logic [YSW-1:0]  w_ysrc;
  logic [14:0]     w_read_addr;
  logic [7:0]      w_pix;

  assign w_run       = (r_state == RUN);
  assign w_last      = (r_x == r_xmax) && (r_y == r_ymax);
  assign w_xsrc      = XSW'(r_x >> r_shift);
  assign w_ysrc      = YSW'(r_y >> r_shift);
  assign w_read_addr = 15'(w_ysrc) * 15'(SRC_W) + 15'(w_xsrc);
  assign read_addr   = w_run ? w_read_addr : '0;

`ifdef PIXEL_REPLICATION_ROW_BUFFER_EN
  logic [7:0]     r_lb [SRC_W];
  logic [7:0]     r_lb_q;
  logic           r_lb_sel;
  logic [XSW-1:0] r_xsrc1;
  logic           w_first_row;

  always_comb begin
    w_first_row = 1'b1;
    case (r_shift)
      2'd1:    w_first_row = ~r_y[0];
      2'd2:    w_first_row = (r_y[1:0] == 2'd0);
      default: w_first_row = 1'b1;
    endcase
  end

  assign read_en = w_run & w_first_row;
  assign w_pix   = r_lb_sel ? r_lb_q : pixel_in;

  // Memory-sourced pixels are captured as they return so later rows of the group can reuse them.
  always_ff @(posedge clk) begin
    if (w_run) r_lb_q <= r_lb[w_xsrc];
    if (r_v1 && !r_lb_sel) r_lb[r_xsrc1] <= pixel_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lb_sel <= 1'b0;
      r_xsrc1  <= '0;
    end else if (w_run) begin
      r_lb_sel <= ~w_first_row;
      r_xsrc1  <= w_xsrc;
    end
  end
`else
  assign read_en = w_run;
  assign w_pix   = pixel_in;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_xmax     <= '0;
      r_ymax     <= '0;
      r_oaddr    <= '0;
      r_wa1      <= '0;
      r_flush    <= 1'b0;
      r_v1       <= 1'b0;
      pixel_out  <= '0;
      write_addr <= '0;
      write_en   <= 1'b0;
      done       <= 1'b0;
    end else begin
      r_v1     <= 1'b0;
      write_en <= r_v1;
      if (r_v1) begin
        pixel_out  <= w_pix;
        write_addr <= r_wa1;
      end
      case (r_state)
        IDLE: begin
          if (enable) begin
            case (zoom_level)
              3'd3:    begin r_shift <= 2'd1; r_xmax <= XM1; r_ymax <= YM1; end
              3'd4:    begin r_shift <= 2'd2; r_xmax <= XM2; r_ymax <= YM2; end
              default: begin r_shift <= 2'd0; r_xmax <= XM0; r_ymax <= YM0; end
            endcase
            r_x     <= '0;
            r_y     <= '0;
            r_oaddr <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (!enable) begin
            write_en <= 1'b0;
            r_state  <= IDLE;
          end else begin
            r_v1    <= 1'b1;
            r_wa1   <= r_oaddr;
            r_oaddr <= r_oaddr + 19'd1;
            if (r_x == r_xmax) begin
              r_x <= '0;
              r_y <= r_y + 9'd1;
            end else begin
              r_x <= r_x + 10'd1;
            end
            if (w_last) begin
              r_flush <= 1'b0;
              r_state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (!enable) begin
            write_en <= 1'b0;
            r_state  <= IDLE;
          end else if (r_flush) begin
            done    <= 1'b1;
            r_state <= DONE;
          end else begin
            r_flush <= 1'b1;
          end
        end
        DONE: begin
          if (!enable) begin
            done    <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
